// File: rtl/lane_pkg.sv
// Framing constants and lock-FSM encoding shared by the lane transmit and receive interfaces.
package lane_pkg;

    localparam logic [1:0]  HDR_DATA   = 2'b01;
    localparam logic [1:0]  HDR_CTRL   = 2'b10;
    localparam logic [63:0] SYNC_WORD  = 64'h78f678f678f678f6;
    localparam logic [5:0]  SCRAM_CTRL = 6'b001010;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic is_sync_word(input logic [1:0] hdr, input logic [63:0] data);
        return (hdr == HDR_CTRL) && (data == SYNC_WORD);
    endfunction

    // Only the top six bits identify a scrambler-state word; the seed bits are don't-care.
    function automatic logic is_scram_word(input logic [1:0] hdr, input logic [5:0] data_top);
        return (hdr == HDR_CTRL) && (data_top == SCRAM_CTRL);
    endfunction

endpackage

// File: rtl/rx_frame_sync.sv
// Metaframe lock FSM: hunts for the sync word, verifies its spacing, and tracks it once locked.
module rx_frame_sync
    import lane_pkg::*;
#(
    parameter int META_FRAME_LEN = 16,
    parameter int LOCK_CNT       = 4,
    parameter int LOSS_CNT       = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              word_valid_i,
    input  logic                              is_sync_i,
    output logic                              locked_o,
    output logic [$clog2(META_FRAME_LEN)-1:0] word_pos_o,
    output logic                              sync_err_o
);

    localparam int CTR_W  = $clog2(META_FRAME_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    logic [1:0]        state_q,    state_d;
    logic [CTR_W-1:0]  word_ctr_q, word_ctr_d;
    logic [GOOD_W-1:0] good_q,     good_d;
    logic [BAD_W-1:0]  bad_q,      bad_d;
    logic              sync_err_q, sync_err_d;

    // NOTE: every signal gets its hold value first so no path through the block leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        word_ctr_d = word_ctr_q;
        good_d     = good_q;
        bad_d      = bad_q;
        sync_err_d = 1'b0;
        if (word_valid_i) begin
            word_ctr_d = (word_ctr_q == CTR_W'(META_FRAME_LEN - 1)) ? '0 : word_ctr_q + CTR_W'(1);
            case (state_q)
                ST_HUNT: begin
                    if (is_sync_i) begin
                        state_d    = ST_VERIFY;
                        word_ctr_d = CTR_W'(1);
                        good_d     = GOOD_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (word_ctr_q == '0) begin
                        if (is_sync_i) begin
                            if (good_q != GOOD_W'(LOCK_CNT)) good_d = good_q + GOOD_W'(1);
                            if (good_q >= GOOD_W'(LOCK_CNT - 1)) begin
                                state_d = ST_LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            sync_err_d = 1'b1;
                            state_d    = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (word_ctr_q == '0) begin
                        if (is_sync_i) begin
                            bad_d = '0;
                        end else begin
                            sync_err_d = 1'b1;
                            if (bad_q != BAD_W'(LOSS_CNT)) bad_d = bad_q + BAD_W'(1);
                            // Position is kept on loss; HUNT realigns on the next sync word anyway.
                            if (bad_q >= BAD_W'(LOSS_CNT - 1)) state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_HUNT;
            word_ctr_q <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_ctr_q <= word_ctr_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign locked_o   = (state_q == ST_LOCKED);
    assign word_pos_o = word_ctr_q;
    assign sync_err_o = sync_err_q;

endmodule

// File: rtl/rx_interface.sv
// Lane receive interface: frame lock via rx_frame_sync, then strips framing/idle words and
// delivers header-01 data words with a one-cycle valid strobe.
module rx_interface
    import lane_pkg::*;
#(
    parameter int META_FRAME_LEN = 16,
    parameter int LOCK_CNT       = 4,
    parameter int LOSS_CNT       = 4
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [63:0] DATA_IN,
    input  logic [1:0]  HEADER_IN,
    input  logic        DATA_IN_VALID,
    output logic [63:0] DATA_OUT,
    output logic        DATA_OUT_VALID,
    output logic        FRAME_LOCK,
    output logic        SYNC_ERR,
    output logic        SCRAM_ERR,
    output logic        HEADER_ERR
);

    localparam int CTR_W = $clog2(META_FRAME_LEN);

    logic             locked;
    logic [CTR_W-1:0] word_pos;
    logic             sync_err;
    logic             is_sync;
    logic             is_scram;

    logic [63:0] data_q,      data_d;
    logic        dvalid_q,    dvalid_d;
    logic        scram_err_q, scram_err_d;
    logic        hdr_err_q,   hdr_err_d;

    assign is_sync  = is_sync_word(HEADER_IN, DATA_IN);
    assign is_scram = is_scram_word(HEADER_IN, DATA_IN[63:58]);

    rx_frame_sync #(
        .META_FRAME_LEN (META_FRAME_LEN),
        .LOCK_CNT       (LOCK_CNT),
        .LOSS_CNT       (LOSS_CNT)
    ) u_frame_sync (
        .clk_i        (USER_CLK),
        .rst_n_i      (SYSTEM_RESET_N),
        .word_valid_i (DATA_IN_VALID),
        .is_sync_i    (is_sync),
        .locked_o     (locked),
        .word_pos_o   (word_pos),
        .sync_err_o   (sync_err)
    );

    // Decisions use the pre-update lock state and position, so lock changes only affect later words.
    always_comb begin
        data_d      = data_q;
        dvalid_d    = 1'b0;
        scram_err_d = 1'b0;
        hdr_err_d   = 1'b0;
        if (DATA_IN_VALID && locked) begin
            if (word_pos == CTR_W'(1)) begin
                scram_err_d = !is_scram;
            end else if (word_pos >= CTR_W'(2)) begin
                case (HEADER_IN)
                    HDR_DATA: begin
                        data_d   = DATA_IN;
                        dvalid_d = 1'b1;
                    end
                    HDR_CTRL: ;
                    default:  hdr_err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (!SYSTEM_RESET_N) begin
            data_q      <= '0;
            dvalid_q    <= 1'b0;
            scram_err_q <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            dvalid_q    <= dvalid_d;
            scram_err_q <= scram_err_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    assign DATA_OUT       = data_q;
    assign DATA_OUT_VALID = dvalid_q;
    assign FRAME_LOCK     = locked;
    assign SYNC_ERR       = sync_err;
    assign SCRAM_ERR      = scram_err_q;
    assign HEADER_ERR     = hdr_err_q;

endmodule

// File: tb/tb_rx_interface.sv
// Directed bench for rx_interface: metaframe generator, data scoreboard and error-pulse counters.
module tb_rx_interface;
    import lane_pkg::*;

    localparam int MFL = 16;
    localparam logic [63:0] SCRAM_OK = {SCRAM_CTRL, 58'h300_0000_0abc};
    localparam logic [63:0] IDLE_W   = 64'h1e1e_1e1e_1e1e_1e1e;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] din;
    logic [1:0]  hin;
    logic        vin;
    logic [63:0] dout;
    logic        dout_valid;
    logic        frame_lock;
    logic        sync_err;
    logic        scram_err;
    logic        hdr_err;

    always #5 clk = ~clk;

    rx_interface #(
        .META_FRAME_LEN (MFL),
        .LOCK_CNT       (4),
        .LOSS_CNT       (4)
    ) dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .DATA_IN        (din),
        .HEADER_IN      (hin),
        .DATA_IN_VALID  (vin),
        .DATA_OUT       (dout),
        .DATA_OUT_VALID (dout_valid),
        .FRAME_LOCK     (frame_lock),
        .SYNC_ERR       (sync_err),
        .SCRAM_ERR      (scram_err),
        .HEADER_ERR     (hdr_err)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          tests_run     = 0;
    int          tests_failed  = 0;
    int          cyc           = 0;
    int          sync_err_cnt  = 0;
    int          scram_err_cnt = 0;
    int          hdr_err_cnt   = 0;
    int          delivered     = 0;
    int          exp_delivered = 0;
    logic [63:0] next_data     = 64'h1;
    bit          use_gaps      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every delivered word and counts error pulses.
    always @(negedge clk) begin
        if (sync_err === 1'b1)  sync_err_cnt++;
        if (scram_err === 1'b1) scram_err_cnt++;
        if (hdr_err === 1'b1)   hdr_err_cnt++;
        if (dout_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'(dout_valid), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("data_out", dout, sb_e.data);
                check("latency_cycle", 64'(cyc), 64'(sb_e.cyc));
                delivered++;
            end
        end
    end

    task automatic drive_word(input logic [1:0] hdr, input logic [63:0] data, input bit push);
        if (use_gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                vin = 1'b0;
                hin = 2'($urandom);
                din = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        vin = 1'b1;
        hin = hdr;
        din = data;
        if (push) begin
            sb_q.push_back('{data: data, cyc: cyc + 1});
            exp_delivered++;
        end
    endtask

    task automatic send_frame(input logic [63:0] w0, input logic [63:0] w1, input bit idle,
                              input bit deliver, input logic exp_lock, input int bad_pos = -1);
        drive_word(HDR_CTRL, w0, 1'b0);
        @(posedge clk);
        #1;
        check("frame_lock_after_pos0", 64'(frame_lock), 64'(exp_lock));
        drive_word(HDR_CTRL, w1, 1'b0);
        for (int p = 2; p < MFL; p++) begin
            if (idle) begin
                drive_word(HDR_CTRL, IDLE_W, 1'b0);
            end else if (p == bad_pos) begin
                drive_word(2'b11, next_data, 1'b0);
                next_data++;
            end else begin
                drive_word(HDR_DATA, next_data, deliver);
                next_data++;
            end
        end
    endtask

    task automatic check_counts(input int es, input int esc, input int eh, input logic el);
        @(negedge clk);
        vin = 1'b0;
        #1;
        check("sync_err_count", 64'(sync_err_cnt), 64'(es));
        check("scram_err_count", 64'(scram_err_cnt), 64'(esc));
        check("header_err_count", 64'(hdr_err_cnt), 64'(eh));
        check("frame_lock", 64'(frame_lock), 64'(el));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        check("delivered_count", 64'(delivered), 64'(exp_delivered));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, dout, 64'd0);
        check({tag, "_data_valid"}, 64'(dout_valid), 64'd0);
        check({tag, "_frame_lock"}, 64'(frame_lock), 64'd0);
        check({tag, "_sync_err"}, 64'(sync_err), 64'd0);
        check({tag, "_scram_err"}, 64'(scram_err), 64'd0);
        check({tag, "_header_err"}, 64'(hdr_err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        vin   = 1'b0;
        hin   = 2'b00;
        din   = 64'd0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire lock with incrementing data; lock rises after the 4th sync word.
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        check_counts(0, 0, 0, 1'b1);

        // Idle stream keeps lock and delivers nothing.
        send_frame(SYNC_WORD, SCRAM_OK, 1'b1, 1'b0, 1'b1);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b1, 1'b0, 1'b1);
        check_counts(0, 0, 0, 1'b1);

        // Three corrupt syncs then a clean one: lock held, loss counter cleared.
        repeat (3) send_frame(64'd0, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        check_counts(3, 0, 0, 1'b1);

        // Four corrupt syncs drop lock on the 4th; four clean syncs relock.
        repeat (3) send_frame(64'd0, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        send_frame(64'd0, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        check_counts(7, 0, 0, 1'b0);
        repeat (3) send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        check_counts(7, 0, 0, 1'b1);

        // Misalignment during VERIFY returns to HUNT without ever locking.
        @(negedge clk);
        rst_n = 1'b0;
        vin   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        drive_word(HDR_CTRL, IDLE_W, 1'b0);
        check_counts(8, 0, 0, 1'b0);
        repeat (3) send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        check_counts(8, 0, 0, 1'b1);

        // Invalid header at position 5, then a bad scrambler-state word.
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1, 5);
        check_counts(8, 0, 1, 1'b1);
        send_frame(SYNC_WORD, 64'd0, 1'b0, 1'b1, 1'b1);
        check_counts(8, 1, 1, 1'b1);

        // One-cycle reset mid-metaframe while locked.
        drive_word(HDR_CTRL, SYNC_WORD, 1'b0);
        drive_word(HDR_CTRL, SCRAM_OK, 1'b0);
        for (int p = 2; p < 7; p++) begin
            drive_word(HDR_DATA, next_data, 1'b1);
            next_data++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        vin   = 1'b1;
        hin   = HDR_DATA;
        din   = next_data;
        @(posedge clk);
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        vin   = 1'b0;

        // Relock and stream data across random valid gaps.
        use_gaps = 1'b1;
        repeat (3) send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b0, 1'b0);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        send_frame(SYNC_WORD, SCRAM_OK, 1'b0, 1'b1, 1'b1);
        check_counts(8, 1, 1, 1'b1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
